// File: rtl/sub_arbiter.sv
// Arbitrates NREQ requesters onto one shared W-bit subtractor (IDLE -> CALC -> HOLD).
// Define SUB_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
//
// state | meaning
// IDLE  | waiting for a request; req_ready grants the arbitration winner combinationally
// CALC  | one cycle computing a + ~b + 1 on the latched operands
// HOLD  | rsp_valid high, result held until rsp_ready
module sub_arbiter #(
  parameter int NREQ = 3,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_borrow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [1:0]      id_q;
  logic [NREQ-1:0] grant;
  logic [1:0]      winner;
  logic            any_req;
  logic [1:0]      start;
  logic [W:0]      sum;

`ifdef SUB_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;
  assign start = ptr;
`else
  assign start = 2'd0;
`endif

  // Search begins at start and wraps modulo NREQ; only indices < NREQ are visited.
  always_comb begin
    int idx;
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req_valid[idx]) begin
        any_req     = 1'b1;
        winner      = 2'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

  // Gated by rst_n so nothing is granted while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;

  assign sum = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_borrow <= 1'b0;
      busy       <= 1'b0;
`ifdef SUB_ARB_ROUND_ROBIN_EN
      ptr        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            a_q   <= req_a[winner*W +: W];
            b_q   <= req_b[winner*W +: W];
            id_q  <= winner;
            busy  <= 1'b1;
            state <= CALC;
`ifdef SUB_ARB_ROUND_ROBIN_EN
            ptr   <= (int'(winner) == NREQ-1) ? 2'd0 : winner + 2'd1;
`endif
          end
        end
        CALC: begin
          rsp_result <= sum[W-1:0];
          rsp_borrow <= ~sum[W];
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed scoreboard bench for sub_arbiter: expected responses queued at accept, checked at handshake.
module tb_sub_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_borrow;
  logic              busy;

  sub_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_borrow(rsp_borrow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] res;
    logic       brw;
  } exp_t;

  exp_t sq[$];
  int   gq[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample point: record accepts into the scoreboard, compare completed responses.
  task automatic mon();
    exp_t e;
    exp_t got;
    if (rst_n && |(req_ready & req_valid)) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          logic [7:0] a;
          logic [7:0] b;
          a     = req_a[i*W +: W];
          b     = req_b[i*W +: W];
          e.id  = 2'(i);
          e.res = 8'(a - b);
          e.brw = (a < b);
          sq.push_back(e);
          gq.push_back(i);
        end
      end
    end
    if (rsp_valid && rsp_ready) begin
      got = {rsp_id, rsp_result, rsp_borrow};
      e   = (sq.size() > 0) ? sq.pop_front() : '1;
      chk("rsp", 32'(got), 32'(e));
    end
  endtask

  task automatic step();
    #1;
    mon();
    @(negedge clk);
  endtask

  task automatic wait_rsp(input string tag);
    int cnt = 1;
    while (!rsp_valid && cnt < 12) begin
      step();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd2);
  endtask

  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b, input string tag);
    req_valid            = '0;
    req_valid[idx]       = 1'b1;
    req_a[idx*W +: W]    = a;
    req_b[idx*W +: W]    = b;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    step();
    req_valid = '0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_rsp(tag);
  endtask

  task automatic finish_op(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int exp_g[4];
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2 rst_n  = 1'b0;
    req_valid = 3'b001;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_borrow", 32'(rsp_borrow), 32'd0);
    @(negedge clk);

    // Grant in the first cycle after reset release.
    rst_n = 1'b1;
    do_op(0, 8'h50, 8'h20, "single");
    finish_op("single");

    do_op(2, 8'h00, 8'h01, "underflow");
    finish_op("underflow");

    do_op(1, 8'h10, 8'h30, "bp");
    req_valid = 3'b001;
    req_a[7:0] = 8'hFF;
    req_b[7:0] = 8'h00;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", 32'(rsp_result), 32'hE0);
      chk("bp_borrow", 32'(rsp_borrow), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    do_op(0, 8'hFF, 8'h00, "max");
    finish_op("max");

    do_op(2, 8'hA5, 8'hA5, "equal");
    finish_op("equal");

    // Contention: all requesters held valid, downstream always ready.
    req_valid = 3'b111;
    req_a     = {8'h33, 8'h22, 8'h11};
    req_b     = {8'h03, 8'h44, 8'h01};
    rsp_ready = 1'b1;
    gq.delete();
    n = 0;
    while (gq.size() < 4 && n < 20) begin
      step();
      n++;
    end
    req_valid = '0;
    while (sq.size() > 0 && n < 40) begin
      step();
      n++;
    end
    rsp_ready = 1'b0;
    chk("cont_grants", 32'(gq.size()), 32'd4);
    chk("cont_drain", 32'(sq.size()), 32'd0);
`ifdef SUB_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_grant%0d", k), 32'((gq.size() > k) ? gq[k] : -1), 32'(exp_g[k]));
    end

    // Reset while a result is held: discarded, no response afterwards.
    do_op(1, 8'h80, 8'h7F, "rsthold");
    #2 rst_n = 1'b0;
    #1;
    chk("rsthold_valid", 32'(rsp_valid), 32'd0);
    chk("rsthold_busy", 32'(busy), 32'd0);
    chk("rsthold_result", 32'(rsp_result), 32'd0);
    sq.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rsthold_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    rsp_ready = 1'b0;

    do_op(1, 8'h01, 8'h02, "post_rst");
    finish_op("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
